femto_bus_fabric: RTL and testbench
===================================

# femto_bus_fabric

Parametrised memory-mapped interconnect between the FemtoRV32 core and N peripheral slaves (SPI flash, SPI RAM, UART, mult, …). Decodes the upper address page to a one-hot select and registers the selected slave for the response phase. Aggregates per-slave busy flags and enforces a bus timeout. Provides an internal status register recording decode and protocol errors.

## Interface
- NUM_SLAVES, 8: number of slave ports (1–16).
- SLAVE_PAGES, {8{16'h0000}}: packed NUM_SLAVES×16-bit vector; slave i owns addresses whose mem_addr[31:16] equals SLAVE_PAGES[16i+:16].
- DEFAULT_SLAVE, 0: index selected when no page matches.
- STATUS_PAGE, 16'h00FF: page of the internal status register; matching takes priority over slaves.
- TIMEOUT_CYCLES, 255: maximum busy cycles per transaction (8-bit counter).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_wmask  in  4  write byte mask; nonzero = write strobe.
- mem_rstrb  in  1  read strobe.
- mem_rdata  out  32  read data to CPU.
- mem_rbusy  out  1  read in progress.
- mem_wbusy  out  1  write in progress.
- s_rd  out  NUM_SLAVES  per-slave read strobe.
- s_wr  out  NUM_SLAVES  per-slave write strobe.
- s_rdata  in  NUM_SLAVES×32  packed slave read data; slave i at [32i+:32].
- s_rbusy  in  NUM_SLAVES  per-slave read busy.
- s_wbusy  in  NUM_SLAVES  per-slave write busy.
- bus_err  out  1  OR of sticky error bits.

## Operation
- Decode is combinational on mem_addr[31:16]: STATUS_PAGE → internal; else lowest matching index; else DEFAULT_SLAVE.
- FSM states: IDLE, RWAIT, WWAIT.
- A strobe is accepted in IDLE, or in the completion cycle of RWAIT/WWAIT (selected busy low).
- Accepted read: s_rd[sel]=1 for that cycle; latch rd_idx; go RWAIT; clear the counter.
- Accepted write: s_wr[sel]=1 for that cycle; latch wr_idx; go WWAIT; clear the counter.
- Strobe arriving while the current slave is still busy: not forwarded; set OVERLAP.
- mem_rstrb and nonzero mem_wmask in the same cycle: the read is forwarded, the write is dropped, COLLISION is set.
- RWAIT: mem_rbusy = s_rbusy[rd_idx]; exit to IDLE when low (unless a new strobe is accepted).
- WWAIT: mem_wbusy = s_wbusy[wr_idx]; exit to IDLE when low.
- mem_rdata = s_rdata[rd_idx] in every state; when rd_idx is internal, mem_rdata = status word.
- Status word: bit0 TIMEOUT, bit1 OVERLAP, bit2 COLLISION, [15:8] slave index of the last error, [31:16] page of the last error.
  - Status bits are sticky.
  - Any write to STATUS_PAGE clears them.
  - Internal accesses never assert busy.

## Timing
- Zero-wait slave: strobe at cycle T; slave data valid with busy low at T+1; CPU samples mem_rdata at T+1.
- Busy slaves raise busy at T+1. mem_rbusy/mem_wbusy follow with zero added latency.
- s_rd/s_wr are combinational in the strobe cycle, forced 0 while rst=1.
- Timeout: counter increments each RWAIT/WWAIT cycle with busy high.
  - At count == TIMEOUT_CYCLES, the FSM goes to IDLE and busy deasserts that cycle.
  - For a read, mem_rdata = ERR_VALUE 32'hDEADBEEF for that one cycle.
  - TIMEOUT is set and the index/page are latched.
- Reset values:
  - state IDLE; rd_idx = wr_idx = DEFAULT_SLAVE; counter 0; status 0.
  - mem_rbusy = 0, mem_wbusy = 0, bus_err = 0.
- Reset mid-transaction: abandon it; busies read 0 from the next cycle; no error recorded.

## Configuration
- FEMTO_BUS_TIMEOUT_EN defined: the timeout counter, ERR_VALUE substitution and TIMEOUT bit are present.
- Undefined: no counter; RWAIT/WWAIT wait indefinitely; status bit0 reads 0.

## Structure
- Package femto_bus_pkg:
  - FSM state encoding.
  - ERR_VALUE.
  - Status bit positions.
  - Default STATUS_PAGE.
- Sub-module femto_bus_decoder: combinational priority page match → one-hot select + index + internal flag.
- FSM, counter, status register and response mux stay in femto_bus_fabric.

## Test plan
- Zero-wait read: NUM_SLAVES=4, pages {0000,0001,0040,0042}; read 0x00400010, slave 2 returns 0x12345678 at T+1 → s_rd=4'b0100 at T, mem_rdata=0x12345678, mem_rbusy never 1.
- Busy write: write to 0x00010004 with s_wbusy[1] high for 5 cycles → s_wr[1] pulses 1 cycle, mem_wbusy high exactly 5 cycles, status stays 0.
- Unmapped address: read 0x12340000 → DEFAULT_SLAVE selected; then read 0x00FF0000 → 0x00000000 with no busy.
- Timeout (FEMTO_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=10): slave 1 holds rbusy forever → mem_rbusy drops after 10 cycles, mem_rdata=0xDEADBEEF, status=0x00010101, bus_err=1; write 0x00FF0000 clears bus_err.
- Collision/overlap: rstrb with wmask=4'hF → only s_rd pulses, status bit2=1; strobe during busy → not forwarded, bit1=1.
- Reset mid-read: assert rst during RWAIT → next cycle mem_rbusy=0, state IDLE, status=0.

Source files
------------

// File: rtl/femto_bus_pkg.sv
// Shared definitions for the FemtoRV32 bus fabric: FSM encoding, error
// read value, status-word bit positions and the default status page.
package femto_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RWAIT = 2'd1,
        ST_WWAIT = 2'd2
    } bus_state_t;

    localparam logic [31:0] ERR_VALUE           = 32'hDEADBEEF;
    localparam int          STAT_TIMEOUT        = 0;
    localparam int          STAT_OVERLAP        = 1;
    localparam int          STAT_COLLISION      = 2;
    localparam logic [15:0] DEFAULT_STATUS_PAGE = 16'h00FF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/femto_bus_decoder.sv
// Combinational page decoder: status page wins, then the lowest-index slave
// whose page matches, otherwise the default slave.
module femto_bus_decoder
    import femto_bus_pkg::*;
#(
    parameter int                      NUM_SLAVES    = 8,
    parameter logic [NUM_SLAVES*16-1:0] SLAVE_PAGES  = {NUM_SLAVES{16'h0000}},
    parameter int                      DEFAULT_SLAVE = 0,
    parameter logic [15:0]             STATUS_PAGE   = DEFAULT_STATUS_PAGE,
    parameter int                      IDX_W         = idx_width(NUM_SLAVES)
) (
    input  logic [15:0]           page_i,
    output logic [NUM_SLAVES-1:0] sel_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  int_o
);

    logic [NUM_SLAVES-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
            assign match[gi] = (page_i == SLAVE_PAGES[16*gi +: 16]);
        end
    endgenerate

    always_comb begin
        sel_o = '0;
        idx_o = IDX_W'(DEFAULT_SLAVE);
        int_o = (page_i == STATUS_PAGE);
        // Walk downwards so the lowest matching index is the one that sticks.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_o = IDX_W'(i);
            end
        end
        if (!int_o) begin
            sel_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/femto_bus_fabric.sv
// FemtoRV32 memory-mapped interconnect with busy aggregation and error status.
// Optional bus timeout is enabled by defining FEMTO_BUS_TIMEOUT_EN.
module femto_bus_fabric
    import femto_bus_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*16-1:0] SLAVE_PAGES    = {NUM_SLAVES{16'h0000}},
    parameter int                       DEFAULT_SLAVE  = 0,
    parameter logic [15:0]              STATUS_PAGE    = DEFAULT_STATUS_PAGE,
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wmask,
    input  logic                       mem_rstrb,
    output logic [31:0]                mem_rdata,
    output logic                       mem_rbusy,
    output logic                       mem_wbusy,
    output logic [NUM_SLAVES-1:0]      s_rd,
    output logic [NUM_SLAVES-1:0]      s_wr,
    input  logic [NUM_SLAVES*32-1:0]   s_rdata,
    input  logic [NUM_SLAVES-1:0]      s_rbusy,
    input  logic [NUM_SLAVES-1:0]      s_wbusy,
    output logic                       bus_err
);

    localparam int IDX_W = idx_width(NUM_SLAVES);

    logic [15:0]           page;
    logic [NUM_SLAVES-1:0] dec_sel;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_int;
    logic [7:0]            dec_err_idx;

    bus_state_t       state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
    logic             rd_int_q, rd_int_d, wr_int_q, wr_int_d;
    logic [15:0]      page_q, page_d;
    logic [2:0]       flags_q, flags_d;
    logic [7:0]       err_idx_q, err_idx_d;
    logic [15:0]      err_page_q, err_page_d;

    logic [31:0] status_word;
    logic [31:0] rdata_arr [NUM_SLAVES];
    logic        sel_rbusy, sel_wbusy, cur_busy, timeout_hit;
    logic        wr_strb, can_accept, rd_acc, wr_acc;
    logic        unused_inputs;

    assign page          = mem_addr[31:16];
    assign unused_inputs = ^{mem_wdata, mem_addr[15:0]};

    femto_bus_decoder #(
        .NUM_SLAVES    (NUM_SLAVES),
        .SLAVE_PAGES   (SLAVE_PAGES),
        .DEFAULT_SLAVE (DEFAULT_SLAVE),
        .STATUS_PAGE   (STATUS_PAGE),
        .IDX_W         (IDX_W)
    ) u_decoder (
        .page_i (page),
        .sel_o  (dec_sel),
        .idx_o  (dec_idx),
        .int_o  (dec_int)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
            assign rdata_arr[gi] = s_rdata[32*gi +: 32];
        end
    endgenerate

    // Internal (status) transactions never stall the CPU.
    assign sel_rbusy = !rd_int_q && s_rbusy[rd_idx_q];
    assign sel_wbusy = !wr_int_q && s_wbusy[wr_idx_q];
    assign cur_busy  = (state_q == ST_RWAIT) ? sel_rbusy :
                       (state_q == ST_WWAIT) ? sel_wbusy : 1'b0;

`ifdef FEMTO_BUS_TIMEOUT_EN
    logic [7:0] cnt_q;

    assign timeout_hit = cur_busy && (cnt_q == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rd_acc || wr_acc || timeout_hit || state_q == ST_IDLE) begin
            cnt_q <= '0;
        end else if (cur_busy) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign wr_strb     = |mem_wmask;
    assign can_accept  = !cur_busy;
    assign rd_acc      = can_accept && mem_rstrb;
    assign wr_acc      = can_accept && wr_strb && !mem_rstrb;
    assign dec_err_idx = dec_int ? 8'hFF : 8'(dec_idx);

    assign s_rd = (!rst && rd_acc && !dec_int) ? dec_sel : '0;
    assign s_wr = (!rst && wr_acc && !dec_int) ? dec_sel : '0;

    assign mem_rbusy   = !rst && (state_q == ST_RWAIT) && sel_rbusy && !timeout_hit;
    assign mem_wbusy   = !rst && (state_q == ST_WWAIT) && sel_wbusy && !timeout_hit;
    assign status_word = {err_page_q, err_idx_q, 5'b0, flags_q};
    assign bus_err     = |flags_q;

    always_comb begin
        if (timeout_hit && state_q == ST_RWAIT) begin
            mem_rdata = ERR_VALUE;
        end else if (rd_int_q) begin
            mem_rdata = status_word;
        end else begin
            mem_rdata = rdata_arr[rd_idx_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_idx_d   = rd_idx_q;
        rd_int_d   = rd_int_q;
        wr_idx_d   = wr_idx_q;
        wr_int_d   = wr_int_q;
        page_d     = page_q;
        flags_d    = flags_q;
        err_idx_d  = err_idx_q;
        err_page_d = err_page_q;

        if (rd_acc) begin
            state_d  = ST_RWAIT;
            rd_idx_d = dec_idx;
            rd_int_d = dec_int;
            page_d   = page;
        end else if (wr_acc) begin
            state_d  = ST_WWAIT;
            wr_idx_d = dec_idx;
            wr_int_d = dec_int;
            page_d   = page;
        end else if (state_q != ST_IDLE && (!cur_busy || timeout_hit)) begin
            state_d = ST_IDLE;
        end

        if (wr_acc && dec_int) begin
            flags_d    = '0;
            err_idx_d  = '0;
            err_page_d = '0;
        end else begin
            if (mem_rstrb && wr_strb) begin
                flags_d[STAT_COLLISION] = 1'b1;
                err_idx_d               = dec_err_idx;
                err_page_d              = page;
            end
            if ((mem_rstrb || wr_strb) && !can_accept) begin
                flags_d[STAT_OVERLAP] = 1'b1;
                err_idx_d             = dec_err_idx;
                err_page_d            = page;
            end
            // A timeout outranks a rejected strobe in the same cycle.
            if (timeout_hit) begin
                flags_d[STAT_TIMEOUT] = 1'b1;
                err_idx_d             = 8'((state_q == ST_RWAIT) ? rd_idx_q : wr_idx_q);
                err_page_d            = page_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_idx_q   <= IDX_W'(DEFAULT_SLAVE);
            wr_idx_q   <= IDX_W'(DEFAULT_SLAVE);
            rd_int_q   <= 1'b0;
            wr_int_q   <= 1'b0;
            page_q     <= '0;
            flags_q    <= '0;
            err_idx_q  <= '0;
            err_page_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            rd_int_q   <= rd_int_d;
            wr_int_q   <= wr_int_d;
            page_q     <= page_d;
            flags_q    <= flags_d;
            err_idx_q  <= err_idx_d;
            err_page_q <= err_page_d;
        end
    end

endmodule

// File: tb/tb_femto_bus_fabric.sv
// Randomized transaction-level bench for femto_bus_fabric with simple
// latency-programmable slave models and a status-word reference model.
module tb_femto_bus_fabric;

    localparam int          NS      = 4;
    localparam int          DEF     = 3;
    localparam int          TO      = 10;
    localparam logic [63:0] PAGES   = {16'h0042, 16'h0040, 16'h0001, 16'h0000};
`ifdef FEMTO_BUS_TIMEOUT_EN
    localparam bit          TO_EN   = 1'b1;
`else
    localparam bit          TO_EN   = 1'b0;
`endif

    logic            clk, rst;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wmask;
    logic            mem_rstrb, mem_rbusy, mem_wbusy, bus_err;
    logic [NS-1:0]   s_rd, s_wr, s_rbusy, s_wbusy;
    logic [NS*32-1:0] s_rdata;

    femto_bus_fabric #(
        .NUM_SLAVES     (NS),
        .SLAVE_PAGES    (PAGES),
        .DEFAULT_SLAVE  (DEF),
        .STATUS_PAGE    (16'h00FF),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .s_rd      (s_rd),
        .s_wr      (s_wr),
        .s_rdata   (s_rdata),
        .s_rbusy   (s_rbusy),
        .s_wbusy   (s_wbusy),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave models: after a strobe, hold busy for the programmed latency.
    int          rlat = 0, wlat = 0;
    logic [7:0]  rcnt [NS] = '{default: 8'd0};
    logic [7:0]  wcnt [NS] = '{default: 8'd0};
    logic [31:0] sdata [NS];

    always @(posedge clk) begin
        for (int j = 0; j < NS; j++) begin
            if (s_rd[j])           rcnt[j] <= 8'(rlat);
            else if (rcnt[j] != 0) rcnt[j] <= rcnt[j] - 8'd1;
            if (s_wr[j])           wcnt[j] <= 8'(wlat);
            else if (wcnt[j] != 0) wcnt[j] <= wcnt[j] - 8'd1;
        end
    end

    always_comb begin
        s_rbusy = '0;
        s_wbusy = '0;
        s_rdata = '0;
        for (int j = 0; j < NS; j++) begin
            s_rbusy[j]          = (rcnt[j] != 0);
            s_wbusy[j]          = (wcnt[j] != 0);
            s_rdata[32*j +: 32] = sdata[j];
        end
    end

    // Reference model of the address map and the sticky status register.
    logic [15:0] page_tab [NS] = '{16'h0000, 16'h0001, 16'h0040, 16'h0042};
    logic [2:0]  m_flags;
    logic [7:0]  m_idx;
    logic [15:0] m_page;
    int          n_checks = 0, n_errors = 0, n_txn = 0;

    function automatic int exp_slave(input logic [15:0] pg);
        for (int j = 0; j < NS; j++) if (pg == page_tab[j]) return j;
        return DEF;
    endfunction

    function automatic logic [31:0] m_word();
        return {m_page, m_idx, 5'b0, m_flags};
    endfunction

    task automatic m_error(input int bitpos, input int idx, input logic [15:0] pg);
        m_flags[bitpos] = 1'b1;
        m_idx           = 8'(idx);
        m_page          = pg;
    endtask

    task automatic m_clear();
        m_flags = '0;
        m_idx   = '0;
        m_page  = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] wm, input int lat);
        logic [15:0] pg;
        bit          is_int, timed;
        int          idx, busy, exp_busy;
        logic [31:0] exp_data;
        pg     = addr[31:16];
        is_int = (pg == 16'h00FF);
        idx    = exp_slave(pg);
        rlat   = lat;
        for (int j = 0; j < NS; j++) sdata[j] = $urandom;
        @(negedge clk);
        mem_addr = addr; mem_rstrb = 1'b1; mem_wmask = wm;
        #1;
        check("s_rd", 32'(s_rd), is_int ? 32'd0 : 32'(1 << idx));
        check("s_wr_on_read", 32'(s_wr), 32'd0);
        if (wm != 0) m_error(2, idx, pg);
        @(negedge clk);
        mem_rstrb = 1'b0; mem_wmask = 4'h0;
        #1;
        busy = 0;
        while (mem_rbusy && busy < 300) begin
            busy++;
            @(negedge clk); #1;
        end
        timed    = !is_int && TO_EN && lat > TO;
        exp_busy = is_int ? 0 : (timed ? TO : lat);
        check("rbusy_cycles", 32'(busy), 32'(exp_busy));
        if (timed) begin
            check("rdata_timeout", mem_rdata, 32'hDEADBEEF);
            m_error(0, idx, pg);
            @(negedge clk); #1;
            check("rdata_after_timeout", mem_rdata, sdata[idx]);
        end else begin
            exp_data = is_int ? m_word() : sdata[idx];
            check("rdata", mem_rdata, exp_data);
        end
        check("bus_err", 32'(bus_err), 32'(m_flags != 0));
        n_txn++;
        $display("txn %0d RD addr=%08h wm=%h lat=%0d busy=%0d rdata=%08h", n_txn, addr, wm, lat, busy, mem_rdata);
    endtask

    task automatic do_write(input logic [31:0] addr, input int lat);
        logic [15:0] pg;
        bit          is_int, timed;
        int          idx, busy;
        pg     = addr[31:16];
        is_int = (pg == 16'h00FF);
        idx    = exp_slave(pg);
        wlat   = lat;
        @(negedge clk);
        mem_addr = addr; mem_wdata = $urandom; mem_wmask = 4'($urandom_range(1, 15)); mem_rstrb = 1'b0;
        #1;
        check("s_wr", 32'(s_wr), is_int ? 32'd0 : 32'(1 << idx));
        check("s_rd_on_write", 32'(s_rd), 32'd0);
        if (is_int) m_clear();
        @(negedge clk);
        mem_wmask = 4'h0;
        #1;
        busy = 0;
        while (mem_wbusy && busy < 300) begin
            busy++;
            @(negedge clk); #1;
        end
        timed = !is_int && TO_EN && lat > TO;
        check("wbusy_cycles", 32'(busy), 32'(is_int ? 0 : (timed ? TO : lat)));
        if (timed) m_error(0, idx, pg);
        check("bus_err", 32'(bus_err), 32'(m_flags != 0));
        n_txn++;
        $display("txn %0d WR addr=%08h lat=%0d busy=%0d", n_txn, addr, lat, busy);
    endtask

    logic [15:0] rnd_pages [6] = '{16'h0000, 16'h0001, 16'h0040, 16'h0042, 16'h00FF, 16'h1234};

    initial begin
        int          kind, busy;
        logic [15:0] pg;
        logic [31:0] a;
        rst = 1'b1; mem_addr = '0; mem_wdata = '0; mem_wmask = '0; mem_rstrb = 1'b0;
        for (int j = 0; j < NS; j++) sdata[j] = $urandom;
        m_clear();
        repeat (3) @(negedge clk);
        #1;
        check("rst_rbusy", 32'(mem_rbusy), 32'd0);
        check("rst_wbusy", 32'(mem_wbusy), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_rdata_default", mem_rdata, sdata[DEF]);

        do_read(32'h0040_0010, 4'h0, 0);
        do_write(32'h0001_0004, 5);
        do_read(32'h00FF_0000, 4'h0, 0);
        do_read(32'h1234_0000, 4'h0, 3);
        do_read(32'h0000_0008, 4'hF, 2);
        do_read(32'h00FF_0000, 4'h0, 0);
        do_write(32'h00FF_0000, 0);

        // Slave 1 stays busy far beyond the timeout limit.
        do_read(32'h0001_0000, 4'h0, 60);
        repeat (60) @(negedge clk);
        do_read(32'h00FF_0000, 4'h0, 0);
        if (TO_EN) check("timeout_status", m_word(), 32'h0001_0101);
        do_write(32'h00FF_0000, 0);

        for (int t = 0; t < 60; t++) begin
            kind = $urandom_range(0, 99);
            pg   = rnd_pages[$urandom_range(0, 5)];
            a    = {pg, 16'($urandom)};
            if (kind < 55) begin
                do_read(a, 4'h0, $urandom_range(0, 14));
            end else if (kind < 85) begin
                do_write(a, $urandom_range(0, 14));
            end else if (kind < 92) begin
                if (pg == 16'h00FF) a[31:16] = 16'h0040;
                do_read(a, 4'($urandom_range(1, 15)), $urandom_range(0, 6));
            end else if (kind < 96) begin
                do_read({16'h00FF, 16'($urandom)}, 4'h0, 0);
            end else begin
                do_write({16'h00FF, 16'($urandom)}, 0);
            end
        end

        // Overlap: second strobe while slave 2 is still busy.
        do_write(32'h00FF_0000, 0);
        rlat = 5;
        @(negedge clk); mem_addr = 32'h0040_0000; mem_rstrb = 1'b1;
        @(negedge clk); mem_rstrb = 1'b0;
        @(negedge clk); mem_addr = 32'h0001_0000; mem_rstrb = 1'b1;
        #1;
        check("overlap_not_forwarded", 32'(s_rd), 32'd0);
        m_error(1, 1, 16'h0001);
        @(negedge clk); mem_rstrb = 1'b0;
        #1;
        busy = 0;
        while (mem_rbusy && busy < 300) begin
            busy++;
            @(negedge clk); #1;
        end
        check("overlap_bus_err", 32'(bus_err), 32'd1);
        do_read(32'h00FF_0000, 4'h0, 0);
        do_write(32'h00FF_0000, 0);

        // Reset in the middle of a busy read (collision leaves an error behind).
        rlat = 8;
        @(negedge clk); mem_addr = 32'h0040_0000; mem_rstrb = 1'b1; mem_wmask = 4'hF;
        @(negedge clk); mem_rstrb = 1'b0; mem_wmask = 4'h0;
        #1;
        check("midrst_busy_before", 32'(mem_rbusy), 32'd1);
        check("midrst_err_before", 32'(bus_err), 32'd1);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #1;
        m_clear();
        check("midrst_rbusy_after", 32'(mem_rbusy), 32'd0);
        check("midrst_err_after", 32'(bus_err), 32'd0);
        do_read(32'h00FF_0000, 4'h0, 0);
        do_read(32'h0000_0004, 4'h0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
